targ_pred_mtb: RTL and testbench
================================

Name: targ_pred_mtb

Overview:
- Parametrised multi-target branch target buffer for the parallel-branch front end.
- Given a fetch PC, it returns up to TARG_CNT learned target PCs, ordered by confidence.
- Trained by feedback from the execute stage; generalises the fixed 3-target predictor interface to configurable set count, target count and tag width.
- Sits beside fetch. Fetch uses the response to spawn parallel paths and to feed the branch predictor.

Parameters:
- SET_CNT, 64, number of direct-mapped sets; power of two, at least 2.
- TARG_CNT, 3, target slots per set and maximum predictions per response; range 1..8.
- TAG_WIDTH, 16, tag bits taken from pc above the index; tag = pc[2+IDX_W +: TAG_WIDTH], where IDX_W = $clog2(SET_CNT).
- CONF_WIDTH, 2, width of the saturating confidence counter per slot.

Ports:
- clk, in, 1, sole clock; all state updates on the rising edge.
- rst, in, 1, synchronous active-high reset.
- req_valid, in, 1, lookup request valid.
- req_base_pc, in, 32, PC to look up.
- rsp_valid, out, 1, response valid; equals req_valid delayed by one cycle.
- rsp_pred_pc, out, 32*TARG_CNT, slot k in bits [32k +: 32]; slot 0 holds the highest confidence.
- rsp_pred_cnt, out, $clog2(TARG_CNT+1), number of valid entries in rsp_pred_pc.
- fb_valid, in, 1, training feedback valid.
- fb_base_pc, in, 32, PC of the resolved control-transfer instruction.
- fb_targ_pc, in, 32, actual resolved target.

Behaviour:
- Reset: every set's valid bit and every slot valid bit clear in the reset cycle; all confidences go to 0. All outputs are 0 in the cycle after rst is high: rsp_valid=0, rsp_pred_cnt=0, rsp_pred_pc=0. While rst is high, requests and feedback are ignored. Reset mid-operation drops any in-flight response.
- Set state: tag, set_valid, and per slot {targ_pc[31:1], slot_valid, conf}. Targets are stored with bit 0 forced to 0.
- Lookup has fixed 1-cycle latency and is fully pipelined, accepting one request per cycle with no stall.
  - Hit (set_valid and tag match): output the valid slots sorted by conf descending; ties go to the lower slot index. Unused upper rsp_pred_pc entries are 0. rsp_pred_cnt = number of valid slots.
  - Miss: rsp_pred_cnt=0 and all rsp_pred_pc = 0.
  - The response is registered. When req_valid=0, the following cycle has rsp_valid=0 and the other response outputs are 0.
- Feedback is applied at the clock edge of the fb_valid cycle.
  - Tag miss or set invalid: install the new tag, clear all slots, write slot 0 = fb_targ_pc with conf=1.
  - Tag hit, target present in slot j: conf[j] increments, saturating at 2^CONF_WIDTH-1. Every other valid slot's conf decrements, saturating at 0; slots stay valid at 0.
  - Tag hit, target absent: allocate the lowest-index invalid slot. If all slots are valid, replace the slot with the lowest conf (lowest index on a tie). The new slot gets conf=1; other slots are unchanged.
- Request and feedback to the same set in the same cycle: the lookup reads pre-update state (read-before-write). The new state is visible to a request one cycle later.
- Index wraps naturally: pc[2 +: IDX_W]. PC bits 1:0 are ignored for indexing and tagging.
- Count arithmetic: rsp_pred_cnt is computed at width $clog2(TARG_CNT+1), so TARG_CNT=3 gives 2 bits, max value 3, and TARG_CNT=4 gives 3 bits.
- No X may propagate from uninitialised storage: reads are gated by the valid bits.

Decomposition:
- Add to package core:
  - localparam int default_targ_cnt = 3 (max_targ_pred_cnt takes this value);
  - typedef mtb_slot_t {sys addr targ, bool valid, logic [CONF_WIDTH-1:0] conf}, expressed as a parametrised struct via a width-fixed default;
  - function conf_sat_inc and conf_sat_dec.
- Sub-module targ_pred_sort: combinational stable sort by conf over TARG_CNT slots, producing the compacted output and count. It is instantiated once on the read path before the response register.

Test Plan:
- Reset then lookup 0x1000 -> next cycle rsp_valid=1, rsp_pred_cnt=0, all rsp_pred_pc=0.
- fb (0x1000 -> 0x2000), then req 0x1000 -> rsp_pred_cnt=1, pc[0]=0x2000.
- Targets are confidence-ordered:
  - Stimulus, in order: fb 0x1000 -> 0x2000; fb 0x1000 -> 0x3000 twice.
  - Expected confs: 0x3000=2, 0x2000=0.
  - Req 0x1000 -> cnt=2, pc[0]=0x3000, pc[1]=0x2000.
- Replacement (TARG_CNT=3):
  - Fill 0x1000 with targets A, B, C, then train A twice.
  - Expected confs: A=3, B=0, C=0.
  - fb 0x1000 -> D replaces B (slot 1, lowest conf, lowest index).
  - Lookup -> A, D, C with cnt=3.
- Aliasing: with SET_CNT=64, a pc differing from 0x1000 only in the tag bits (0x1000+0x100) replaces the set. A lookup of 0x1000 then returns cnt=0.
- Same-cycle req and fb to a new tag:
  - Response that cycle shows the old contents.
  - Request next cycle shows only the new target with cnt=1.
  - Asserting rst between request and response forces rsp_valid=0 the following cycle.

Source files
------------

// File: rtl/targ_pred_mtb_pkg.sv
// Shared types and helpers for the multi-target branch target buffer.
package targ_pred_mtb_pkg;

  localparam int default_targ_cnt  = 3;
  localparam int max_targ_pred_cnt = default_targ_cnt;

  // The slot struct carries a fixed-width confidence field wide enough for any
  // supported CONF_WIDTH (1..8); only the low CONF_WIDTH bits are ever non-zero.
  localparam int max_conf_width = 8;

  typedef logic [31:0] addr_t;

  typedef struct packed {
    logic [31:1]               targ;
    logic                      valid;
    logic [max_conf_width-1:0] conf;
  } mtb_slot_t;

  // Saturating increment, ceiling at 2^width-1.
  function automatic logic [max_conf_width-1:0] conf_sat_inc(
    input logic [max_conf_width-1:0] conf,
    input int                        width
  );
    logic [max_conf_width-1:0] conf_max;
    conf_max = max_conf_width'((1 << width) - 1);
    return (conf >= conf_max) ? conf_max : conf + 1'b1;
  endfunction

  // Saturating decrement, floor at 0.
  function automatic logic [max_conf_width-1:0] conf_sat_dec(
    input logic [max_conf_width-1:0] conf
  );
    return (conf == '0) ? '0 : conf - 1'b1;
  endfunction

endpackage

// File: rtl/targ_pred_sort.sv
// Combinational stable sort of slots by confidence (descending, ties to the
// lower slot index), compacting valid slots into the low output lanes.
module targ_pred_sort
  import targ_pred_mtb_pkg::*;
#(
  parameter int TARG_CNT = 3,
  parameter int CNT_W    = 2
) (
  input  mtb_slot_t [TARG_CNT-1:0] slots,
  output logic [32*TARG_CNT-1:0]   pred_pc,
  output logic [CNT_W-1:0]         pred_cnt
);

  int rank [TARG_CNT];

  // Rank of each slot = number of valid slots that must precede it.
  always_comb begin
    for (int i = 0; i < TARG_CNT; i++) begin
      rank[i] = 0;
      for (int j = 0; j < TARG_CNT; j++) begin
        if (j != i && slots[j].valid &&
            (slots[j].conf > slots[i].conf ||
             (slots[j].conf == slots[i].conf && j < i)))
          rank[i] = rank[i] + 1;
      end
    end
  end

  // Valid-slot count; valid ranks are exactly 0..count-1.
  always_comb begin
    pred_cnt = '0;
    for (int i = 0; i < TARG_CNT; i++)
      if (slots[i].valid) pred_cnt = pred_cnt + CNT_W'(1);
  end

  genvar gi;
  generate
    for (gi = 0; gi < TARG_CNT; gi++) begin : gen_lane
      logic [31:0] lane;
      // Each output lane picks the valid slot whose rank equals its position.
      always_comb begin
        lane = '0;
        for (int i = 0; i < TARG_CNT; i++)
          if (slots[i].valid && rank[i] == gi) lane = lane | {slots[i].targ, 1'b0};
      end
      assign pred_pc[32*gi +: 32] = lane;
    end
  endgenerate

endmodule

// File: rtl/targ_pred_mtb.sv
// Multi-target branch target buffer: direct-mapped sets of TARG_CNT targets
// with saturating confidence, 1-cycle registered lookup, execute-stage training.
module targ_pred_mtb
  import targ_pred_mtb_pkg::*;
#(
  parameter int SET_CNT    = 64,
  parameter int TARG_CNT   = 3,
  parameter int TAG_WIDTH  = 16,
  parameter int CONF_WIDTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  input  logic [31:0]                     req_base_pc,
  output logic                            rsp_valid,
  output logic [32*TARG_CNT-1:0]          rsp_pred_pc,
  output logic [$clog2(TARG_CNT+1)-1:0]   rsp_pred_cnt,
  input  logic                            fb_valid,
  input  logic [31:0]                     fb_base_pc,
  input  logic [31:0]                     fb_targ_pc
);

  localparam int IDX_W = $clog2(SET_CNT);
  localparam int CNT_W = $clog2(TARG_CNT+1);

  mtb_slot_t              slot_reg [SET_CNT][TARG_CNT];
  logic [TAG_WIDTH-1:0]   tag_reg  [SET_CNT];
  logic [SET_CNT-1:0]     set_valid_reg;

  // Bits outside index/tag (and target bit 0) are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{req_base_pc, fb_base_pc, fb_targ_pc[0]};

  // ---------------- lookup path ----------------
  logic [IDX_W-1:0]          req_idx;
  logic [TAG_WIDTH-1:0]      req_tag;
  logic                      req_hit;
  mtb_slot_t [TARG_CNT-1:0]  lk_slots;
  logic [32*TARG_CNT-1:0]    sort_pc;
  logic [CNT_W-1:0]          sort_cnt;

  assign req_idx = req_base_pc[2 +: IDX_W];
  assign req_tag = req_base_pc[2+IDX_W +: TAG_WIDTH];
  assign req_hit = req_valid && set_valid_reg[req_idx] && (tag_reg[req_idx] == req_tag);

  // Present only valid slots of a hitting set to the sorter; everything else reads as 0.
  always_comb begin
    for (int k = 0; k < TARG_CNT; k++) begin
      lk_slots[k]       = '0;
      if (req_hit && slot_reg[req_idx][k].valid) lk_slots[k] = slot_reg[req_idx][k];
    end
  end

  targ_pred_sort #(
    .TARG_CNT (TARG_CNT),
    .CNT_W    (CNT_W)
  ) u_sort (
    .slots    (lk_slots),
    .pred_pc  (sort_pc),
    .pred_cnt (sort_cnt)
  );

  // Response register; reads pre-update state when feedback hits the same set.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_pred_pc  <= '0;
      rsp_pred_cnt <= '0;
    end else begin
      rsp_valid    <= req_valid;
      rsp_pred_pc  <= sort_pc;
      rsp_pred_cnt <= sort_cnt;
    end
  end

  // ---------------- training path ----------------
  logic [IDX_W-1:0]          fb_idx;
  logic [TAG_WIDTH-1:0]      fb_tag;
  logic                      fb_hit;
  mtb_slot_t [TARG_CNT-1:0]  fb_next;
  mtb_slot_t                 new_slot;
  logic                      match_found, inv_found;
  int                        match_idx, inv_idx, min_idx, alloc_idx;
  logic [max_conf_width-1:0] min_conf;

  assign fb_idx = fb_base_pc[2 +: IDX_W];
  assign fb_tag = fb_base_pc[2+IDX_W +: TAG_WIDTH];
  assign fb_hit = set_valid_reg[fb_idx] && (tag_reg[fb_idx] == fb_tag);

  // Compute the trained contents of the addressed set.
  always_comb begin
    new_slot       = '0;
    new_slot.targ  = fb_targ_pc[31:1];
    new_slot.valid = 1'b1;
    new_slot.conf  = max_conf_width'(1);

    match_found = 1'b0;
    match_idx   = 0;
    inv_found   = 1'b0;
    inv_idx     = 0;
    min_idx     = 0;
    min_conf    = slot_reg[fb_idx][0].conf;
    for (int k = 0; k < TARG_CNT; k++) begin
      if (!match_found && slot_reg[fb_idx][k].valid &&
          slot_reg[fb_idx][k].targ == fb_targ_pc[31:1]) begin
        match_found = 1'b1;
        match_idx   = k;
      end
      if (!inv_found && !slot_reg[fb_idx][k].valid) begin
        inv_found = 1'b1;
        inv_idx   = k;
      end
      if (slot_reg[fb_idx][k].conf < min_conf) begin
        min_conf = slot_reg[fb_idx][k].conf;
        min_idx  = k;
      end
    end
    alloc_idx = inv_found ? inv_idx : min_idx;

    for (int k = 0; k < TARG_CNT; k++) begin
      fb_next[k] = slot_reg[fb_idx][k];
      if (!fb_hit) begin
        fb_next[k] = (k == 0) ? new_slot : '0;
      end else if (match_found) begin
        if (k == match_idx)
          fb_next[k].conf = conf_sat_inc(slot_reg[fb_idx][k].conf, CONF_WIDTH);
        else if (slot_reg[fb_idx][k].valid)
          fb_next[k].conf = conf_sat_dec(slot_reg[fb_idx][k].conf);
      end else if (k == alloc_idx) begin
        fb_next[k] = new_slot;
      end
    end
  end

  // Set storage; reset clears every valid bit and confidence in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      set_valid_reg <= '0;
      for (int s = 0; s < SET_CNT; s++)
        for (int k = 0; k < TARG_CNT; k++) begin
          slot_reg[s][k].valid <= 1'b0;
          slot_reg[s][k].conf  <= '0;
        end
    end else if (fb_valid) begin
      set_valid_reg[fb_idx] <= 1'b1;
      tag_reg[fb_idx]       <= fb_tag;
      for (int k = 0; k < TARG_CNT; k++)
        slot_reg[fb_idx][k] <= fb_next[k];
    end
  end

endmodule

// File: tb/tb_targ_pred_mtb.sv
// Directed, table-driven bench for targ_pred_mtb with default parameters.
module tb_targ_pred_mtb;

  localparam int OP_RST  = 0;
  localparam int OP_FB   = 1;
  localparam int OP_REQ  = 2;
  localparam int OP_IDLE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_base_pc = '0;
  logic        rsp_valid;
  logic [95:0] rsp_pred_pc;
  logic [1:0]  rsp_pred_cnt;
  logic        fb_valid = 1'b0;
  logic [31:0] fb_base_pc = '0;
  logic [31:0] fb_targ_pc = '0;

  int tests = 0;
  int fails = 0;

  targ_pred_mtb dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_base_pc  (req_base_pc),
    .rsp_valid    (rsp_valid),
    .rsp_pred_pc  (rsp_pred_pc),
    .rsp_pred_cnt (rsp_pred_cnt),
    .fb_valid     (fb_valid),
    .fb_base_pc   (fb_base_pc),
    .fb_targ_pc   (fb_targ_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          op;
    logic [31:0] pc;
    logic [31:0] targ;
    logic        ev;
    logic [1:0]  ecnt;
    logic [31:0] e0, e1, e2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int op, input logic [31:0] pc, input logic [31:0] targ,
                              input logic ev, input logic [1:0] ecnt,
                              input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.op = op; v.pc = pc; v.targ = targ; v.ev = ev; v.ecnt = ecnt;
    v.e0 = e0; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic check(input string name, input logic ev, input logic [1:0] ec,
                       input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    logic [95:0] ep;
    ep = {e2, e1, e0};
    tests++;
    if (rsp_valid !== ev) begin
      fails++;
      $display("FAIL %s rsp_valid got %b want %b", name, rsp_valid, ev);
    end
    tests++;
    if (rsp_pred_cnt !== ec) begin
      fails++;
      $display("FAIL %s rsp_pred_cnt got %0d want %0d", name, rsp_pred_cnt, ec);
    end
    tests++;
    if (rsp_pred_pc !== ep) begin
      fails++;
      $display("FAIL %s rsp_pred_pc got %h want %h", name, rsp_pred_pc, ep);
    end
    $display("[TB] %s valid=%b cnt=%0d pc=%h", name, rsp_valid, rsp_pred_cnt, rsp_pred_pc);
  endtask

  // Drive one cycle of inputs, then release them just after the edge.
  task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc,
                       input logic fv, input logic [31:0] fpc, input logic [31:0] ftg);
    rst = r; req_valid = rv; req_base_pc = rpc;
    fb_valid = fv; fb_base_pc = fpc; fb_targ_pc = ftg;
    @(posedge clk);
    #1;
    rst = 1'b0; req_valid = 1'b0; fb_valid = 1'b0;
  endtask

  localparam logic [31:0] A = 32'h2000, B = 32'h3000, C = 32'h4000, D = 32'h5000;

  initial begin
    // Reset also carries a request and feedback, both of which must be ignored.
    vecs.push_back(mk(OP_RST,  32'h1100, 32'h9000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_REQ,  32'h1100, 0,        1, 0, 0, 0, 0));
    vecs.push_back(mk(OP_REQ,  32'h1000, 0,        1, 0, 0, 0, 0));
    vecs.push_back(mk(OP_IDLE, 32'h1000, 0,        0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_FB,   32'h1000, A,        0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_REQ,  32'h1000, 0,        1, 1, A, 0, 0));
    vecs.push_back(mk(OP_FB,   32'h1000, B,        0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_FB,   32'h1000, B,        0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_REQ,  32'h1000, 0,        1, 2, B, A, 0));
    vecs.push_back(mk(OP_REQ,  32'h1004, 0,        1, 0, 0, 0, 0));
    // Replacement: A=3, B=0, C=0, then D (odd target) evicts B.
    vecs.push_back(mk(OP_RST,  32'h0,    0,        0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_FB,   32'h1000, A,        0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_FB,   32'h1000, B,        0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_FB,   32'h1000, C,        0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_FB,   32'h1000, A,        0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_FB,   32'h1000, A,        0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_REQ,  32'h1000, 0,        1, 3, A, B, C));
    vecs.push_back(mk(OP_FB,   32'h1000, D | 1,    0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_REQ,  32'h1000, 0,        1, 3, A, D, C));
    // A saturates at 3; D drops to 0; C then rises.
    vecs.push_back(mk(OP_FB,   32'h1000, A,        0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_FB,   32'h1000, C,        0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_REQ,  32'h1000, 0,        1, 3, A, C, D));
    vecs.push_back(mk(OP_FB,   32'h1000, C,        0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_FB,   32'h1000, C,        0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_REQ,  32'h1000, 0,        1, 3, C, A, D));
    // Aliasing: same index, different tag replaces the set.
    vecs.push_back(mk(OP_FB,   32'h1100, 32'h6000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_REQ,  32'h1000, 0,        1, 0, 0, 0, 0));
    vecs.push_back(mk(OP_REQ,  32'h1100, 0,        1, 1, 32'h6000, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      string nm;
      v = vecs[i];
      nm = $sformatf("vec%0d", i);
      cycle(v.op == OP_RST, v.op == OP_REQ || v.op == OP_RST, v.pc,
            v.op == OP_FB || v.op == OP_RST, v.pc, v.targ);
      check(nm, v.ev, v.ecnt, v.e0, v.e1, v.e2);
    end

    // Same-cycle request to the old tag and feedback installing a new tag.
    cycle(0, 1, 32'h1100, 1, 32'h1000, 32'h7000);
    check("rbw_old", 1, 1, 32'h6000, 0, 0);
    cycle(0, 1, 32'h1000, 0, 0, 0);
    check("rbw_new", 1, 1, 32'h7000, 0, 0);
    cycle(0, 1, 32'h1100, 0, 0, 0);
    check("rbw_alias_gone", 1, 0, 0, 0, 0);

    // Reset arriving with an in-flight request drops the response.
    cycle(0, 1, 32'h1000, 0, 0, 0);
    check("pre_rst", 1, 1, 32'h7000, 0, 0);
    cycle(1, 1, 32'h1000, 0, 0, 0);
    check("rst_drop", 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h1000, 0, 0, 0);
    check("post_rst", 1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
